// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the MIPS multicycle controller.
// MIPS_CTRL_TRAP_EN adds the TRAP state encoding.
package mips_ctrl_pkg;

  localparam int ALUOP_W_DEF  = 4;
  localparam int REGDST_W_DEF = 2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  localparam logic [ALUOP_W_DEF-1:0] ALU_SLL = 4'h0;
  localparam logic [ALUOP_W_DEF-1:0] ALU_SRL = 4'h2;
  localparam logic [ALUOP_W_DEF-1:0] ALU_SRA = 4'h3;
  localparam logic [ALUOP_W_DEF-1:0] ALU_SLT = 4'h5;
  localparam logic [ALUOP_W_DEF-1:0] ALU_SUB = 4'hA;
  localparam logic [ALUOP_W_DEF-1:0] ALU_ADD = 4'hB;
  localparam logic [ALUOP_W_DEF-1:0] ALU_AND = 4'hC;
  localparam logic [ALUOP_W_DEF-1:0] ALU_OR  = 4'hD;
  localparam logic [ALUOP_W_DEF-1:0] ALU_NOR = 4'hF;

  localparam logic [REGDST_W_DEF-1:0] RD_RT = 2'd0;
  localparam logic [REGDST_W_DEF-1:0] RD_RD = 2'd1;
  localparam logic [REGDST_W_DEF-1:0] RD_RA = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
`ifdef MIPS_CTRL_TRAP_EN
    , S_TRAP = 3'd5
`endif
  } state_t;

  function automatic logic op_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_J, OP_JAL, OP_BEQ,
                      OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
                      OP_ANDI, OP_ORI, OP_LW, OP_SW};
  endfunction

  function automatic logic func_legal(input logic [5:0] f);
    return f inside {F_SLL, F_SRL, F_SRA, F_JR, F_ADD,
                     F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
                     F_NOR, F_SLT};
  endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// ALU control decode: latched opcode/func to ALU code,
// operand source and immediate extension mode.
module mips_alu_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]             op,
  input  logic [5:0]             func,
  output logic [ALUOP_W_DEF-1:0] code,
  output logic                   alusrc,
  output logic                   zext
);

  logic [ALUOP_W_DEF-1:0] rcode;

  always_comb begin
    rcode = ALU_SLL;
    unique case (func)
      F_ADD, F_ADDU: rcode = ALU_ADD;
      F_SUB, F_SUBU: rcode = ALU_SUB;
      F_AND:         rcode = ALU_AND;
      F_OR:          rcode = ALU_OR;
      F_NOR:         rcode = ALU_NOR;
      F_SLT:         rcode = ALU_SLT;
      F_SRL:         rcode = ALU_SRL;
      F_SRA:         rcode = ALU_SRA;
      default:       rcode = ALU_SLL;
    endcase
  end

  always_comb begin
    code   = ALU_SLL;
    alusrc = 1'b0;
    zext   = 1'b0;
    unique case (1'b1)
      (op == OP_RTYPE): code = rcode;
      (op == OP_ADDI), (op == OP_ADDIU),
      (op == OP_LW), (op == OP_SW): begin
        code   = ALU_ADD;
        alusrc = 1'b1;
      end
      (op == OP_SLTI): begin
        code   = ALU_SLT;
        alusrc = 1'b1;
      end
      (op == OP_ANDI): begin
        code   = ALU_AND;
        alusrc = 1'b1;
        zext   = 1'b1;
      end
      (op == OP_ORI): begin
        code   = ALU_OR;
        alusrc = 1'b1;
        zext   = 1'b1;
      end
      (op == OP_BEQ), (op == OP_BNE): code = ALU_SUB;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with imem/dmem wait states.
// MIPS_CTRL_TRAP_EN: illegal instructions park in TRAP.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W  = 4,
  parameter int REGDST_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic                branch,
  output logic                branch_ne,
  output logic                jump,
  output logic                jump_reg,
  output logic [ALUOP_W-1:0]  aluop,
  output logic                alusrc,
  output logic                zext,
  output logic [REGDST_W-1:0] regdst,
  output logic                memtoreg,
  output logic                regwrite,
  output logic                readmem,
  output logic                writemem,
`ifdef MIPS_CTRL_TRAP_EN
  output logic                illegal_instr,
`endif
  output logic [2:0]          state_o
);

  state_t     state;
  logic [5:0] op_q;
  logic [5:0] func_q;
  logic       req_q;

  logic [ALUOP_W_DEF-1:0] alu_code;
  logic                   dec_alusrc;
  logic                   dec_zext;

  logic fetch_go;
  logic is_rtype, is_jr, is_ralu, is_imm;
  logic is_lw, is_sw, is_beq, is_bne;
  logic is_j, is_jal;
  logic unused_instr;

  assign unused_instr = ^instr[25:6];

  // req_q marks the first cycle after reset release as idle
  assign fetch_go = (state == S_FETCH) & req_q & imem_ready;

  assign is_rtype = (op_q == OP_RTYPE);
  assign is_jr    = is_rtype & (func_q == F_JR);
  assign is_ralu  = is_rtype & ~is_jr;
  assign is_imm   = op_q inside {OP_ADDI, OP_ADDIU,
                                 OP_SLTI, OP_ANDI,
                                 OP_ORI};
  assign is_lw    = (op_q == OP_LW);
  assign is_sw    = (op_q == OP_SW);
  assign is_beq   = (op_q == OP_BEQ);
  assign is_bne   = (op_q == OP_BNE);
  assign is_j     = (op_q == OP_J);
  assign is_jal   = (op_q == OP_JAL);

  mips_alu_decode u_alu_decode (
    .op     (op_q),
    .func   (func_q),
    .code   (alu_code),
    .alusrc (dec_alusrc),
    .zext   (dec_zext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      op_q   <= 6'd0;
      func_q <= 6'd0;
      req_q  <= 1'b0;
    end else begin
      req_q <= 1'b1;
      unique case (state)
        S_FETCH: begin
          if (fetch_go) begin
            op_q   <= instr[31:26];
            func_q <= instr[5:0];
            state  <= S_DECODE;
          end
        end
        S_DECODE: begin
`ifdef MIPS_CTRL_TRAP_EN
          if (!op_legal(op_q) ||
              (is_rtype && !func_legal(func_q)))
            state <= S_TRAP;
          else
            state <= S_EXEC;
`else
          state <= S_EXEC;
`endif
        end
        S_EXEC: begin
          unique case (1'b1)
            (is_lw | is_sw):     state <= S_MEM;
            (is_ralu | is_imm):  state <= S_WB;
            default:             state <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (dmem_ready)
            state <= is_lw ? S_WB : S_FETCH;
        end
        S_WB: state <= S_FETCH;
`ifdef MIPS_CTRL_TRAP_EN
        S_TRAP: state <= S_TRAP;
`endif
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    jump      = 1'b0;
    jump_reg  = 1'b0;
    aluop     = '0;
    alusrc    = 1'b0;
    zext      = 1'b0;
    regdst    = REGDST_W'(RD_RT);
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    readmem   = 1'b0;
    writemem  = 1'b0;
`ifdef MIPS_CTRL_TRAP_EN
    illegal_instr = 1'b0;
`endif
    unique case (state)
      S_FETCH: begin
        imem_req = req_q;
        ir_write = fetch_go;
        pc_write = fetch_go;
      end
      S_DECODE: ;
      S_EXEC: begin
        aluop     = ALUOP_W'(alu_code);
        alusrc    = dec_alusrc;
        zext      = dec_zext;
        branch    = is_beq;
        branch_ne = is_bne;
        jump      = is_j | is_jal;
        jump_reg  = is_jr;
        if (is_jal) begin
          regwrite = 1'b1;
          regdst   = REGDST_W'(RD_RA);
        end
      end
      S_MEM: begin
        readmem  = is_lw;
        writemem = is_sw;
      end
      S_WB: begin
        regwrite = 1'b1;
        memtoreg = is_lw;
        regdst   = is_ralu ? REGDST_W'(RD_RD)
                           : REGDST_W'(RD_RT);
      end
`ifdef MIPS_CTRL_TRAP_EN
      S_TRAP: illegal_instr = 1'b1;
`endif
      default: ;
    endcase
  end

  assign state_o = state;

endmodule
